// File: rtl/axi_mem_slave_if.sv
// AXI4 slave bus bundle (AW/W/B/AR/R) used by the word-addressed memory slave.
interface axi_mem_slave_if #(
    parameter int unsigned ID_W = 1
);
    logic [ID_W-1:0] S_AXI_AWID;
    logic [31:0]     S_AXI_AWADDR;
    logic [7:0]      S_AXI_AWLEN;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [31:0]     S_AXI_WDATA;
    logic [3:0]      S_AXI_WSTRB;
    logic            S_AXI_WLAST;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;
    logic [ID_W-1:0] S_AXI_BID;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;
    logic [ID_W-1:0] S_AXI_ARID;
    logic [31:0]     S_AXI_ARADDR;
    logic [7:0]      S_AXI_ARLEN;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [ID_W-1:0] S_AXI_RID;
    logic [31:0]     S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RLAST;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 INCR-only memory slave: 32-bit words, independent read and write FSMs.
module axi_mem_slave #(
    parameter int unsigned C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int unsigned C_MEM_WORDS             = 1024
) (
    input  logic            ACLK,
    input  logic            ARESETN,
    axi_mem_slave_if.slave  s_axi
);
    localparam int unsigned ID_W  = C_M_AXI_THREAD_ID_WIDTH;
    localparam int unsigned IDX_W = $clog2(C_MEM_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [31:0] mem [C_MEM_WORDS];

    w_state_t         w_state, w_state_d;
    logic [ID_W-1:0]  w_id, w_id_d;
    logic [IDX_W-1:0] w_idx, w_idx_d;
    logic [7:0]       w_cnt, w_cnt_d;
    logic             w_err, w_err_d;
    logic [1:0]       b_resp, b_resp_d;
    logic             w_we_c;
    logic             aw_ready, w_ready, b_valid;

    r_state_t         r_state, r_state_d;
    logic [ID_W-1:0]  r_id, r_id_d;
    logic [IDX_W-1:0] r_idx, r_idx_d;
    logic [7:0]       r_cnt, r_cnt_d;
    logic [31:0]      r_data;
    logic             r_valid, r_last, ar_ready;

    // Address bits outside the word index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi.S_AXI_AWADDR[31:IDX_W+2], s_axi.S_AXI_AWADDR[1:0],
                                s_axi.S_AXI_ARADDR[31:IDX_W+2], s_axi.S_AXI_ARADDR[1:0]};

    // Write FSM next state; error flag tracks WLAST disagreeing with the beat counter.
    always_comb begin
        w_state_d = w_state;
        w_id_d    = w_id;
        w_idx_d   = w_idx;
        w_cnt_d   = w_cnt;
        w_err_d   = w_err;
        b_resp_d  = b_resp;
        w_we_c    = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (s_axi.S_AXI_AWVALID) begin
                    w_id_d    = s_axi.S_AXI_AWID;
                    w_idx_d   = s_axi.S_AXI_AWADDR[IDX_W+1:2];
                    w_cnt_d   = s_axi.S_AXI_AWLEN;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi.S_AXI_WVALID) begin
                    w_we_c  = 1'b1;
                    w_idx_d = w_idx + IDX_W'(1);
                    if (s_axi.S_AXI_WLAST != (w_cnt == 8'd0)) begin
                        w_err_d = 1'b1;
                    end
                    if (w_cnt == 8'd0) begin
                        b_resp_d  = (w_err || !s_axi.S_AXI_WLAST) ? 2'b10 : 2'b00;
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d = w_cnt - 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM state and registered write-channel outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state  <= W_IDLE;
            w_id     <= '0;
            w_idx    <= '0;
            w_cnt    <= '0;
            w_err    <= 1'b0;
            b_resp   <= 2'b00;
            aw_ready <= 1'b1;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
        end else begin
            w_state  <= w_state_d;
            w_id     <= w_id_d;
            w_idx    <= w_idx_d;
            w_cnt    <= w_cnt_d;
            w_err    <= w_err_d;
            b_resp   <= b_resp_d;
            aw_ready <= (w_state_d == W_IDLE);
            w_ready  <= (w_state_d == W_DATA);
            b_valid  <= (w_state_d == W_RESP);
        end
    end

    // Byte-masked memory write; contents intentionally survive reset.
    always_ff @(posedge ACLK) begin
        if (w_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi.S_AXI_WSTRB[b]) begin
                    mem[w_idx][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    // Read FSM next state: one fetch cycle before every beat.
    always_comb begin
        r_state_d = r_state;
        r_id_d    = r_id;
        r_idx_d   = r_idx;
        r_cnt_d   = r_cnt;
        unique case (r_state)
            R_IDLE: begin
                if (s_axi.S_AXI_ARVALID) begin
                    r_id_d    = s_axi.S_AXI_ARID;
                    r_idx_d   = s_axi.S_AXI_ARADDR[IDX_W+1:2];
                    r_cnt_d   = s_axi.S_AXI_ARLEN;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: r_state_d = R_DATA;
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) begin
                    if (r_cnt == 8'd0) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d   = r_cnt - 8'd1;
                        r_idx_d   = r_idx + IDX_W'(1);
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM state, fetched word and registered read-channel outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state  <= R_IDLE;
            r_id     <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            ar_ready <= 1'b1;
        end else begin
            r_state  <= r_state_d;
            r_id     <= r_id_d;
            r_idx    <= r_idx_d;
            r_cnt    <= r_cnt_d;
            if (r_state == R_FETCH) begin
                r_data <= mem[r_idx];
            end
            r_valid  <= (r_state_d == R_DATA);
            r_last   <= (r_state_d == R_DATA) && (r_cnt_d == 8'd0);
            ar_ready <= (r_state_d == R_IDLE);
        end
    end

    assign s_axi.S_AXI_AWREADY = aw_ready;
    assign s_axi.S_AXI_WREADY  = w_ready;
    assign s_axi.S_AXI_BID     = w_id;
    assign s_axi.S_AXI_BRESP   = b_resp;
    assign s_axi.S_AXI_BVALID  = b_valid;
    assign s_axi.S_AXI_ARREADY = ar_ready;
    assign s_axi.S_AXI_RID     = r_id;
    assign s_axi.S_AXI_RDATA   = r_data;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign s_axi.S_AXI_RLAST   = r_last;
    assign s_axi.S_AXI_RVALID  = r_valid;
endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter C_M_AXI_THREAD_ID_WIDTH, default 1: AXI ID width.
REQ-002 SHALL have parameter C_MEM_WORDS, default 1024: number of 32-bit words; power of two, 16..65536.
REQ-003 SHALL use one clock, ACLK, and reset ARESETN; reset is asynchronous and active-low.
REQ-004 SHALL have the ports below (name, direction, width, meaning):
- ACLK  in  1  bus clock, rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWID  in  ID  write burst ID.
- S_AXI_AWADDR  in  32  write byte address.
- S_AXI_AWLEN  in  8  write beats minus 1.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables; bit n covers WDATA[8n+7:8n].
- S_AXI_WLAST  in  1  last write beat.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BID  out  ID  response ID.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  response valid.
- S_AXI_BREADY  in  1  response ready.
- S_AXI_ARID  in  ID  read burst ID.
- S_AXI_ARADDR  in  32  read byte address.
- S_AXI_ARLEN  in  8  read beats minus 1.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RID  out  ID  read data ID.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response, always 2'b00.
- S_AXI_RLAST  out  1  last read beat.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.

Function
REQ-005 SHALL not implement SIZE, BURST, LOCK, CACHE, PROT, QOS or USER ports. Every burst SHALL be treated as INCR with 4-byte beats.
REQ-006 SHALL form the word index as ADDR[log2(C_MEM_WORDS)+1:2]. ADDR[1:0] and the upper bits SHALL be ignored. The index SHALL increment by 1 per beat, modulo C_MEM_WORDS, so an address past the top wraps to word 0.
REQ-007 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP:
- AWREADY=1 only in W_IDLE.
- On an AW handshake, latch AWID, the word index and beat count = AWLEN, then go to W_DATA.
REQ-008 In W_DATA, WREADY SHALL be 1. On each W handshake:
- write each byte whose WSTRB bit is 1 into the current word; bytes with WSTRB 0 are unchanged;
- advance the index;
- after beat AWLEN+1, go to W_RESP.
REQ-009 The burst length SHALL come from the beat counter only. If WLAST does not equal (current beat is the last beat) on any beat, a sticky error flag SHALL be set and BRESP SHALL be 2'b10; otherwise BRESP SHALL be 2'b00.
REQ-010 In W_RESP, BVALID SHALL be 1 and BID SHALL equal the latched AWID. BVALID, BID and BRESP SHALL hold until BREADY is 1, then the FSM goes to W_IDLE. A new AW SHALL be accepted no earlier than the cycle after the B handshake.
REQ-011 Read FSM states SHALL be R_IDLE, R_FETCH and R_DATA:
- ARREADY=1 only in R_IDLE.
- On an AR handshake, latch ARID, the index and count = ARLEN, then go to R_FETCH.
- R_FETCH SHALL perform a synchronous memory read for one cycle, then go to R_DATA.
REQ-012 In R_DATA:
- RVALID=1 and RID=ARID.
- RLAST SHALL be 1 only when the remaining count is 0.
- RDATA, RLAST and RID SHALL hold while RREADY is 0.
- On an R handshake: if it was the last beat, go to R_IDLE; otherwise decrement the count, advance the index and go to R_FETCH.
REQ-013 The first RVALID SHALL be seen 2 cycles after the AR handshake edge. Each later beat SHALL be seen 2 cycles after the previous R handshake.
REQ-014 The read and write FSMs SHALL operate concurrently. If a write and a fetch hit the same word in the same cycle, the fetch SHALL return the pre-write data.

Reset
REQ-015 While ARESETN=0:
- both FSMs SHALL be in IDLE;
- AWREADY=1 and ARREADY=1;
- WREADY, BVALID, RVALID and RLAST SHALL be 0;
- BID, BRESP, RID, RDATA and the error flag SHALL be 0.
Memory contents SHALL NOT be reset.
REQ-016 A reset asserted mid-burst SHALL abandon that burst with no B or R response. Beats already written SHALL remain in memory.

Verification
REQ-017 Single write then read: AWADDR=0x10, AWID=1, WDATA=0xDEADBEEF, WSTRB=4'hF, WLAST=1 -> BVALID with BID=1, BRESP=00. Then ARADDR=0x10 -> RDATA=0xDEADBEEF, RLAST=1, RRESP=00, RVALID 2 cycles after the AR handshake.
REQ-018 Byte strobes: write 0x11223344 with WSTRB=4'b0101 to 0x10 (holding 0xDEADBEEF) -> a read returns 0xDE22BE44.
REQ-019 Burst: AWLEN=3 at 0x100 with data 1,2,3,4, WLAST on beat 4 -> BRESP=00. Then ARLEN=3 at 0x100 -> beats 1,2,3,4, with RLAST only on beat 4.
REQ-020 Backpressure:
- RREADY held 0 for 5 cycles -> RVALID and RDATA stable;
- BREADY held 0 -> BVALID held and AWREADY remains 0.
REQ-021 Boundaries (C_MEM_WORDS=1024):
- AWADDR=0xFFC with AWLEN=1 -> second beat lands at word 0;
- WLAST on beat 1 of a 2-beat burst -> BRESP=2'b10;
- ARESETN pulsed during read beat 2 of 4 -> RVALID=0 and ARREADY=1 immediately.
